up_counter_ctrl: RTL and testbench
==================================

# up_counter_ctrl

Synchronous, loadable up-counter with a terminal-count controller. It is the count-up counterpart to the team's ripple down-counter. All bits change on one clock edge, so there is no ripple skew. The block counts from a start or preload value up to a programmable limit, then either wraps or halts, and flags the terminal event. It drives interval timers and sequence indexing in the datapath.

## Interface
- WIDTH, default 4: counter width in bits.
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  synchronous reset, active-low; sampled on the rising clk edge.
- start  in  1  begin counting; acted on only in IDLE or HALT.
- en  in  1  count enable; increments happen only in RUN with en=1.
- load  in  1  synchronous preload of q from din.
- din  in  WIDTH  preload value.
- limit  in  WIDTH  terminal value; compared live every cycle, not latched.
- wrap  in  1  action at the terminal event: 1 = restart at 0 and stay in RUN, 0 = hold at limit and enter HALT.
- q  out  WIDTH  registered count.
- busy  out  1  registered; high while state = RUN.
- tc  out  1  combinational; (state = RUN) and (q = limit).
- done  out  1  registered one-cycle pulse following each terminal event.

## Operation
- States: IDLE, RUN, HALT.
- Reset (rst=0 at an edge) forces q=0, state=IDLE, busy=0, done=0, hence tc=0.
- Priority at each edge: rst > load > start > count.
- load=1:
  - q <= din.
  - No increment that cycle.
  - HALT goes to IDLE; IDLE and RUN keep their state.
  - done <= 0.
- start=1 in IDLE: state goes to RUN; q is kept, so a preloaded value is the first count.
- start=1 in HALT: state goes to RUN and q <= 0.
- start=1 in RUN: ignored.
- RUN, en=0: q holds; no state change.
- RUN, en=1, q != limit: q <= q+1, modulo 2^WIDTH. A q preloaded above limit counts up to all-ones, wraps to 0, and reaches limit later.
- RUN, en=1, q = limit (terminal event): done <= 1.
  - wrap=1: q <= 0 and stay in RUN.
  - wrap=0: q holds at limit; state goes to HALT.
- done is 0 at every edge without a terminal event. It is never high for two consecutive cycles unless terminal events occur on consecutive edges (limit=0, wrap=1).
- limit=0 in RUN with en=1 and wrap=1: a terminal event occurs every edge; q stays 0 and done stays high.
- IDLE and HALT: en is ignored; q holds.

## Timing
- start sampled at edge N: busy=1 after edge N.
  - First increment occurs at edge N+1 if en=1.
  - From q=0 with constant en, q reaches limit after edge N+limit. tc is high in that cycle. The terminal event is at edge N+limit+1, and done is high for the cycle after it.
- The terminal event uses q and limit as they stand just before the edge. A limit change takes effect on the next compare.
- rst=0 mid-RUN overrides load, start and en. Outputs read reset values after that edge.
- Release from reset requires a start; the counter never self-starts.

## Test plan
- Reset then basic count, WIDTH=4:
  - Stimulus: rst=0 for 2 cycles, then start pulse at edge 0, en=1, limit=3, wrap=0.
  - Required: q=0 and busy=0 during reset. q=1,2,3 after edges 1,2,3. tc=1 only in the q=3 cycle. done=1 for one cycle after edge 4. State goes to HALT with busy=0 and q=3.
- Wrap mode:
  - Stimulus: limit=2, wrap=1, en=1.
  - Required: q sequence 0,1,2,0,1,2, …; done pulses each time q returns to 0; busy stays 1.
- Preload above limit:
  - Stimulus: load din=14 in IDLE, then start, en=1, limit=1, wrap=0.
  - Required: q=14,15,0,1, then HALT with q=1; done pulses once.
- Enable gating and load during RUN:
  - Stimulus: drop en for 3 cycles, then assert load din=5 while en=1.
  - Required: q frozen while en=0. After the load edge, q=5 with no increment and busy still 1.
- Restart from HALT and mid-run reset:
  - Stimulus: start in HALT; later, rst=0 while q=7 and en=1.
  - Required: the restart gives q=0 and RUN. The reset edge gives q=0, IDLE, busy=0, done=0, even with start=1 and load=1 asserted in the same cycle.
- limit=0 with wrap=1:
  - Stimulus: limit=0, wrap=1, start, en=1.
  - Required: q stays 0; done=1 every cycle from the first terminal edge onward; tc=1 throughout RUN.

Source files
------------

// File: rtl/up_counter_ctrl.sv
// Synchronous loadable up-counter with an IDLE/RUN/HALT terminal-count controller.
// Counts to a live-compared limit, then wraps to 0 or halts, and pulses done after each terminal event.
module up_counter_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic [WIDTH-1:0] limit,
  input  logic             wrap,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             tc,
  output logic             done,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             at_limit;

  assign at_limit = (q_q == limit);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      q_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Priority: load > start (IDLE/HALT only) > count. A start seen in RUN
  // is ignored, so counting carries on as if it were absent.
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    done_d  = 1'b0;
    if (load) begin
      q_d = din;
      if (state_q == HALT) state_d = IDLE;
    end else if (start && (state_q != RUN)) begin
      state_d = RUN;
      if (state_q == HALT) q_d = '0;
    end else if ((state_q == RUN) && en) begin
      if (at_limit) begin
        done_d = 1'b1;
        if (wrap) q_d = '0;
        else      state_d = HALT;
      end else begin
        q_d = q_q + 1'b1;
      end
    end
    busy_d = (state_d == RUN);
  end

  assign q         = q_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign tc        = (state_q == RUN) && at_limit;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_up_counter_ctrl.sv
// Directed bench for up_counter_ctrl: the driver pushes hand-computed post-edge outputs,
// and a monitor compares them one clock edge later.
module tb_up_counter_ctrl;

  localparam int W  = 4;
  localparam int EW = W + 5;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic         en = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] din = '0;
  logic [W-1:0] limit = '0;
  logic         wrap = 1'b0;
  logic [W-1:0] q;
  logic         busy;
  logic         tc;
  logic         done;
  logic [1:0]   dbg_state;

  // Expected word layout: {q, busy, done, tc, state}
  logic [EW-1:0] exp_q[$];
  string         name_q[$];
  int            n_tests = 0;
  int            n_fail  = 0;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HALT = 2'd2;

  up_counter_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .en(en), .load(load),
    .din(din), .limit(limit), .wrap(wrap),
    .q(q), .busy(busy), .tc(tc), .done(done), .dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Driver: apply inputs on the falling edge, push the outputs expected after the next rising edge
  task automatic step(input logic r, input logic ld, input logic st, input logic e,
                      input logic [W-1:0] d, input logic [W-1:0] lim, input logic wr,
                      input logic [W-1:0] eq, input logic eb, input logic edn,
                      input logic etc, input logic [1:0] es, input string nm);
    @(negedge clk);
    rst = r; load = ld; start = st; en = e; din = d; limit = lim; wrap = wr;
    exp_q.push_back({eq, eb, edn, etc, es});
    name_q.push_back(nm);
  endtask

  // Monitor / scoreboard: every cycle is an output presentation for this block
  always @(posedge clk) begin
    logic [EW-1:0] got, exp;
    string nm;
    #1;
    if (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      nm  = name_q.pop_front();
      got = {q, busy, done, tc, dbg_state};
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL %s: got q=%0d busy=%b done=%b tc=%b st=%0d, want q=%0d busy=%b done=%b tc=%b st=%0d",
                 nm, got[EW-1:5], got[4], got[3], got[2], got[1:0],
                 exp[EW-1:5], exp[4], exp[3], exp[2], exp[1:0]);
      end
    end
  end

  initial begin
    // Reset then basic count, limit=3, wrap=0
    step(0,0,0,0, 0,3,0,  0,0,0,0,S_IDLE, "reset1");
    step(0,0,0,0, 0,3,0,  0,0,0,0,S_IDLE, "reset2");
    step(1,0,0,0, 0,3,0,  0,0,0,0,S_IDLE, "no_self_start");
    step(1,0,1,1, 0,3,0,  0,1,0,0,S_RUN,  "start");
    step(1,0,0,1, 0,3,0,  1,1,0,0,S_RUN,  "cnt1");
    step(1,0,0,1, 0,3,0,  2,1,0,0,S_RUN,  "cnt2");
    step(1,0,0,1, 0,3,0,  3,1,0,1,S_RUN,  "cnt3_tc");
    step(1,0,0,1, 0,3,0,  3,0,1,0,S_HALT, "halt_done");
    step(1,0,0,1, 0,3,0,  3,0,0,0,S_HALT, "halt_hold");
    // Restart from HALT clears q
    step(1,0,1,1, 0,3,0,  0,1,0,0,S_RUN,  "restart");
    // Wrap mode, limit=2
    step(1,0,0,1, 0,2,1,  1,1,0,0,S_RUN,  "wrap_1");
    step(1,0,0,1, 0,2,1,  2,1,0,1,S_RUN,  "wrap_2");
    step(1,0,0,1, 0,2,1,  0,1,1,0,S_RUN,  "wrap_0_done");
    step(1,0,0,1, 0,2,1,  1,1,0,0,S_RUN,  "wrap_1b");
    step(1,0,0,1, 0,2,1,  2,1,0,1,S_RUN,  "wrap_2b");
    step(1,0,0,1, 0,2,1,  0,1,1,0,S_RUN,  "wrap_0b_done");
    // Enable gating then load during RUN
    step(1,0,0,1, 0,2,1,  1,1,0,0,S_RUN,  "gate_pre");
    step(1,0,0,0, 0,2,1,  1,1,0,0,S_RUN,  "gate_hold1");
    step(1,0,0,0, 0,2,1,  1,1,0,0,S_RUN,  "gate_hold2");
    step(1,0,0,0, 0,2,1,  1,1,0,0,S_RUN,  "gate_hold3");
    step(1,1,0,1, 5,2,1,  5,1,0,0,S_RUN,  "load_run");
    step(1,0,1,1, 0,7,0,  6,1,0,0,S_RUN,  "start_in_run");
    step(1,0,0,1, 0,7,0,  7,1,0,1,S_RUN,  "cnt7_tc");
    // Mid-run reset overrides load/start/en
    step(0,1,1,1, 9,7,0,  0,0,0,0,S_IDLE, "midrun_reset");
    // Preload above limit
    step(1,1,0,1,14,1,0, 14,0,0,0,S_IDLE, "preload14");
    step(1,0,1,1, 0,1,0, 14,1,0,0,S_RUN,  "start_pre");
    step(1,0,0,1, 0,1,0, 15,1,0,0,S_RUN,  "pre15");
    step(1,0,0,1, 0,1,0,  0,1,0,0,S_RUN,  "pre_roll0");
    step(1,0,0,1, 0,1,0,  1,1,0,1,S_RUN,  "pre1_tc");
    step(1,0,0,1, 0,1,0,  1,0,1,0,S_HALT, "pre_halt");
    step(1,0,0,1, 0,1,0,  1,0,0,0,S_HALT, "pre_halt_hold");
    // Load in HALT returns to IDLE
    step(1,1,0,0, 0,0,1,  0,0,0,0,S_IDLE, "load_halt");
    // limit=0 with wrap=1
    step(1,0,1,1, 0,0,1,  0,1,0,1,S_RUN,  "l0_start");
    step(1,0,0,1, 0,0,1,  0,1,1,1,S_RUN,  "l0_done1");
    step(1,0,0,1, 0,0,1,  0,1,1,1,S_RUN,  "l0_done2");
    step(1,0,0,1, 0,0,1,  0,1,1,1,S_RUN,  "l0_done3");
    step(1,0,0,0, 0,0,1,  0,1,0,1,S_RUN,  "l0_en_off");
    // Live limit change takes effect on the next compare
    step(1,0,0,1, 0,4,1,  1,1,0,0,S_RUN,  "limit_live");
    // Drain
    repeat (3) @(negedge clk);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
